// File: rtl/target_pkg.sv
// Shared types, constants and helpers for the target generator and other LFSR users.
package target_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    localparam int unsigned LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
    localparam int unsigned TGT_W     = 8;
    localparam int unsigned IDX_W     = 3;

    // Galois, right shift: the bit shifted out decides whether the mask is applied.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        logic [LFSR_W-1:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end
        return nxt;
    endfunction

    function automatic logic [TGT_W-1:0] tgt_onehot(input logic [IDX_W-1:0] idx);
        logic [TGT_W-1:0] t;
        t = TGT_W'(1) << idx;
        return t;
    endfunction

    function automatic logic [IDX_W-1:0] tgt_index(input logic [TGT_W-1:0] t);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < TGT_W; i++) begin
            if (t[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so it never locks up.
module lfsr16
    import target_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    localparam logic [15:0] RST_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/target_gen.sv
// One-hot LED target generator with periodic or on-demand issue and a round counter.
// Optional TARGET_GEN_NOREPEAT_EN: consecutive targets in a run never repeat.
module target_gen
    import target_pkg::*;
#(
    parameter int unsigned PERIOD = 100_000_000,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             advance,
    output logic             freq,
    output logic [TGT_W-1:0] random,
    output logic [7:0]       round
);

    localparam logic [31:0] RELOAD = 32'(PERIOD - 1);

    state_e            state;
    logic [31:0]       cnt;
    logic [LFSR_W-1:0] lfsr;
    logic [IDX_W-1:0]  cand_idx;
    logic [IDX_W-1:0]  act_idx;
    logic              unused_lfsr;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign cand_idx    = lfsr[IDX_W-1:0];
    assign unused_lfsr = ^lfsr[LFSR_W-1:IDX_W];

    // Index used for issues while already running; the first issue after IDLE uses cand_idx.
`ifdef TARGET_GEN_NOREPEAT_EN
    always_comb begin
        act_idx = cand_idx;
        if (cand_idx == tgt_index(random)) begin
            act_idx = cand_idx + 1'b1;
        end
    end
`else
    always_comb begin
        act_idx = cand_idx;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            freq   <= 1'b0;
            random <= '0;
            round  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    freq   <= 1'b0;
                    random <= '0;
                    if (start) begin
                        state  <= ACTIVE;
                        random <= tgt_onehot(cand_idx);
                        freq   <= 1'b1;
                        cnt    <= RELOAD;
                        round  <= 8'd1;
                    end
                end
                ACTIVE: begin
                    if (!start) begin
                        state  <= IDLE;
                        random <= '0;
                        freq   <= 1'b0;
                    end else if ((cnt == 32'd0) || advance) begin
                        random <= tgt_onehot(act_idx);
                        freq   <= 1'b1;
                        cnt    <= RELOAD;
                        if (round != 8'hFF) begin
                            round <= round + 8'd1;
                        end
                    end else begin
                        cnt  <= cnt - 32'd1;
                        freq <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_target_gen.sv
// Directed, table-driven bench for target_gen: timed/advance issue, stop/restart,
// reset, round saturation and zero-seed LFSR behaviour.
module tb_target_gen;

`ifdef TARGET_GEN_NOREPEAT_EN
    localparam bit NR = 1'b1;
`else
    localparam bit NR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, adv_a, freq_a;
    logic [7:0] rnd_a, round_a;
    logic       rst_b, start_b, adv_b, freq_b;
    logic [7:0] rnd_b, round_b;
    logic       rst_c, start_c, adv_c, freq_c;
    logic [7:0] rnd_c, round_c;

    target_gen #(.PERIOD(4), .SEED(16'h0001)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .advance(adv_a),
        .freq(freq_a), .random(rnd_a), .round(round_a)
    );

    target_gen #(.PERIOD(2), .SEED(16'h0001)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .advance(adv_b),
        .freq(freq_b), .random(rnd_b), .round(round_b)
    );

    target_gen #(.PERIOD(4), .SEED(16'h0000)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .advance(adv_c),
        .freq(freq_c), .random(rnd_c), .round(round_c)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    typedef struct {
        logic       start;
        logic       adv;
        logic       freq;
        logic [7:0] rnd_nr;
        logic [7:0] rnd_plain;
        logic [7:0] round;
    } vec_t;

    vec_t vecs[21];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Expected values worked out by hand from the LFSR sequence with SEED=1.
        vecs[0]  = '{1, 0, 1, 8'h02, 8'h02, 8'd1};
        vecs[1]  = '{1, 0, 0, 8'h02, 8'h02, 8'd1};
        vecs[2]  = '{1, 0, 0, 8'h02, 8'h02, 8'd1};
        vecs[3]  = '{1, 0, 0, 8'h02, 8'h02, 8'd1};
        vecs[4]  = '{1, 0, 1, 8'h01, 8'h01, 8'd2};
        vecs[5]  = '{1, 1, 1, 8'h02, 8'h01, 8'd3};
        vecs[6]  = '{1, 1, 1, 8'h01, 8'h01, 8'd4};
        vecs[7]  = '{1, 1, 1, 8'h02, 8'h01, 8'd5};
        vecs[8]  = '{1, 0, 0, 8'h02, 8'h01, 8'd5};
        vecs[9]  = '{1, 0, 0, 8'h02, 8'h01, 8'd5};
        vecs[10] = '{1, 0, 0, 8'h02, 8'h01, 8'd5};
        vecs[11] = '{1, 0, 1, 8'h20, 8'h20, 8'd6};
        vecs[12] = '{1, 0, 0, 8'h20, 8'h20, 8'd6};
        vecs[13] = '{1, 0, 0, 8'h20, 8'h20, 8'd6};
        vecs[14] = '{1, 0, 0, 8'h20, 8'h20, 8'd6};
        vecs[15] = '{1, 1, 1, 8'h04, 8'h04, 8'd7};
        vecs[16] = '{1, 0, 0, 8'h04, 8'h04, 8'd7};
        vecs[17] = '{0, 0, 0, 8'h00, 8'h00, 8'd7};
        vecs[18] = '{0, 1, 0, 8'h00, 8'h00, 8'd7};
        vecs[19] = '{1, 0, 1, 8'h01, 8'h01, 8'd1};
        vecs[20] = '{1, 0, 0, 8'h01, 8'h01, 8'd1};

        rst_a = 1'b1; start_a = 1'b0; adv_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; adv_b = 1'b0;
        rst_c = 1'b1; start_c = 1'b0; adv_c = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_freq", 32'(freq_a), 32'd0);
        check("reset_random", 32'(rnd_a), 32'h00);
        check("reset_round", 32'(round_a), 32'd0);
        rst_a = 1'b0;

        // Main table: inputs set before each edge, outputs sampled 1 time unit after it.
        for (int i = 0; i < 21; i++) begin
            start_a = vecs[i].start;
            adv_a   = vecs[i].adv;
            @(posedge clk);
            #1;
            check($sformatf("edge%0d_freq", i + 1), 32'(freq_a), 32'(vecs[i].freq));
            check($sformatf("edge%0d_random", i + 1), 32'(rnd_a),
                  32'(NR ? vecs[i].rnd_nr : vecs[i].rnd_plain));
            check($sformatf("edge%0d_round", i + 1), 32'(round_a), 32'(vecs[i].round));
        end

        // Asynchronous reset in mid-cycle while running.
        #3;
        rst_a = 1'b1;
        #1;
        check("async_rst_freq", 32'(freq_a), 32'd0);
        check("async_rst_random", 32'(rnd_a), 32'h00);
        check("async_rst_round", 32'(round_a), 32'd0);
        @(posedge clk);
        #1;
        check("held_rst_random", 32'(rnd_a), 32'h00);
        check("held_rst_freq", 32'(freq_a), 32'd0);
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_freq", 32'(freq_a), 32'd1);
        check("post_rst_random", 32'(rnd_a), 32'h02);
        check("post_rst_round", 32'(round_a), 32'd1);

        // Saturation with PERIOD=2: strobes every second edge, round clamps at 255.
        begin
            int strobes;
            int gap;
            int bad_gap;
            int bad_round;
            logic [7:0] exp_round;
            strobes = 0; gap = 0; bad_gap = 0; bad_round = 0;
            rst_b = 1'b0;
            start_b = 1'b1;
            for (int i = 0; i < 600; i++) begin
                @(posedge clk);
                #1;
                gap++;
                if (freq_b) begin
                    strobes++;
                    if (strobes > 1 && gap != 2) bad_gap++;
                    gap = 0;
                end
                exp_round = (strobes > 255) ? 8'd255 : 8'(strobes);
                if (round_b !== exp_round) bad_round++;
            end
            check("sat_strobe_count", 32'(strobes), 32'd300);
            check("sat_gap_errors", 32'(bad_gap), 32'd0);
            check("sat_round_errors", 32'(bad_round), 32'd0);
            check("sat_round_final", 32'(round_b), 32'd255);
        end

        // Zero seed: LFSR starts at 1 and follows the model without reaching 0.
        begin
            logic [15:0] m;
            int bad_model;
            int zero_hits;
            bad_model = 0; zero_hits = 0;
            rst_c = 1'b0;
            #1;
            check("zero_seed_lfsr_init", 32'(dut_c.u_lfsr.q), 32'h0001);
            m = 16'h0001;
            start_c = 1'b1;
            @(posedge clk);
            #1;
            m = model_step(m);
            check("zero_seed_first_random", 32'(rnd_c), 32'h02);
            for (int i = 0; i < 70000; i++) begin
                if (dut_c.u_lfsr.q !== m) bad_model++;
                if (dut_c.u_lfsr.q == 16'h0000) zero_hits++;
                @(posedge clk);
                #1;
                m = model_step(m);
            end
            check("zero_seed_model_errors", 32'(bad_model), 32'd0);
            check("zero_seed_zero_hits", 32'(zero_hits), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
